// File: rtl/sfx_pkg.sv
// Shared types and widths for the sound-effect sample player.
package sfx_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 16;
  localparam logic [DATA_W-1:0] SILENCE = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    READY,
    DONE
  } player_state_t;

  // An effect is in progress in every state except IDLE and DONE.
  function automatic logic is_active(input player_state_t s);
    return (s == FETCH) || (s == WAIT) || (s == READY);
  endfunction

endpackage

// File: rtl/sfx_sample_player_if.sv
// Audio memory read bus: request/ack handshake plus a one-cycle data-valid pulse.
interface sfx_sample_player_if #(
  parameter int unsigned ADDR_W = sfx_pkg::ADDR_W,
  parameter int unsigned DATA_W = sfx_pkg::DATA_W
);

  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_ack;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;

  modport master (
    output mem_rd_req,
    output mem_addr,
    input  mem_rd_ack,
    input  mem_rd_valid,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_req,
    input  mem_addr,
    output mem_rd_ack,
    output mem_rd_valid,
    output mem_rd_data
  );

endinterface

// File: rtl/sfx_mem_rd_port.sv
// Single-outstanding-read port for audio memory. Holds the request until it is
// acked, tracks the read in flight, and drops the data of a read that was
// aborted after its ack so a stale sample never reaches the player.
module sfx_mem_rd_port #(
  parameter int unsigned ADDR_W = sfx_pkg::ADDR_W,
  parameter int unsigned DATA_W = sfx_pkg::DATA_W
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                issue,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                abort,
  output logic                acked,
  output logic                data_valid,
  output logic [DATA_W-1:0]   data,
  sfx_sample_player_if.master mem
);

  logic              req_r;
  logic [ADDR_W-1:0] addr_r;
  logic              inflight;
  logic              discard;

  // Request / in-flight / discard tracking; a new request waits until any
  // outstanding read (including a discarded one) has returned its data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      req_r    <= 1'b0;
      addr_r   <= '0;
      inflight <= 1'b0;
      discard  <= 1'b0;
    end else begin
      if (mem.mem_rd_valid && inflight) begin
        inflight <= 1'b0;
        discard  <= 1'b0;
      end else if (abort && inflight) begin
        discard <= 1'b1;
      end

      if (req_r && mem.mem_rd_ack) begin
        // An ack in the same cycle as an abort still commits the memory to a
        // reply, so that reply is marked for discard.
        req_r    <= 1'b0;
        inflight <= 1'b1;
        discard  <= abort;
      end else if (req_r && abort) begin
        req_r <= 1'b0;
      end else if (issue && !req_r && !inflight) begin
        req_r  <= 1'b1;
        addr_r <= addr;
      end
    end
  end

  assign mem.mem_rd_req = req_r;
  assign mem.mem_addr   = addr_r;
  assign acked          = req_r & mem.mem_rd_ack;
  assign data_valid     = mem.mem_rd_valid & inflight & ~discard;
  assign data           = mem.mem_rd_data;

endmodule

// File: rtl/sfx_sample_player.sv
// Sound-effect playback engine: walks [Start_Addr..End_Addr] in audio memory,
// keeps one sample prefetched, and presents it on each codec sample_tick.
module sfx_sample_player #(
  parameter int unsigned       ADDR_W  = sfx_pkg::ADDR_W,
  parameter int unsigned       DATA_W  = sfx_pkg::DATA_W,
  parameter logic [DATA_W-1:0] SILENCE = DATA_W'(sfx_pkg::SILENCE)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                play,
  input  logic                loop,
  input  logic                Audio_Reset,
  input  logic [ADDR_W-1:0]   Start_Addr,
  input  logic [ADDR_W-1:0]   End_Addr,
  input  logic                sample_tick,
  sfx_sample_player_if.master mem,
  output logic [DATA_W-1:0]   sample_out,
  output logic                busy,
  output logic                underrun
);

  import sfx_pkg::*;

  player_state_t     state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] start_r;
  logic [ADDR_W-1:0] end_r;
  logic              loop_r;
  logic [DATA_W-1:0] pf_data;

  logic              abort;
  logic              rd_issue;
  logic              rd_acked;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  assign abort    = Audio_Reset | ~play;
  assign rd_issue = (state == FETCH) && !abort;
  assign busy     = is_active(state);

  sfx_mem_rd_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rd_port (
    .Clk        (Clk),
    .Reset      (Reset),
    .issue      (rd_issue),
    .addr       (cur_addr),
    .abort      (abort),
    .acked      (rd_acked),
    .data_valid (rd_valid),
    .data       (rd_data),
    .mem        (mem)
  );

  // Player state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; an abort from any state returns to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (play && !Audio_Reset) begin
          state_nxt = (Start_Addr > End_Addr) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (rd_valid) begin
          state_nxt = READY;
        end else if (rd_acked) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (rd_valid) begin
          state_nxt = READY;
        end
      end
      READY: begin
        if (sample_tick) begin
          if (cur_addr == end_r) begin
            state_nxt = loop_r ? FETCH : DONE;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
    end
  end

  // Range latch, address counter, prefetch buffer, sample output and underrun pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cur_addr   <= '0;
      start_r    <= '0;
      end_r      <= '0;
      loop_r     <= 1'b0;
      pf_data    <= '0;
      sample_out <= SILENCE;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (abort) begin
        sample_out <= SILENCE;
      end else begin
        unique case (state)
          IDLE: begin
            start_r  <= Start_Addr;
            end_r    <= End_Addr;
            loop_r   <= loop;
            cur_addr <= Start_Addr;
          end
          FETCH, WAIT: begin
            if (rd_valid) begin
              pf_data <= rd_data;
            end
            if (sample_tick) begin
              underrun <= 1'b1;
            end
          end
          READY: begin
            if (sample_tick) begin
              sample_out <= pf_data;
              if (cur_addr == end_r) begin
                if (loop_r) begin
                  cur_addr <= start_r;
                end
              end else begin
                cur_addr <= cur_addr + ADDR_W'(1);
              end
            end
          end
          DONE: begin
            if (sample_tick) begin
              sample_out <= SILENCE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sfx_sample_player.sv
// Directed bench for sfx_sample_player with a latency-programmable memory model
// and an expected-sample queue checked on every sample_tick.
module tb_sfx_sample_player;

  import sfx_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        play;
  logic        loop;
  logic        Audio_Reset;
  logic [22:0] Start_Addr;
  logic [22:0] End_Addr;
  logic        sample_tick = 1'b0;
  logic [15:0] sample_out;
  logic        busy;
  logic        underrun;

  always #5 Clk = ~Clk;

  sfx_sample_player_if #(.ADDR_W(23), .DATA_W(16)) mif ();

  sfx_sample_player #(
    .ADDR_W  (23),
    .DATA_W  (16),
    .SILENCE (16'h0000)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .play        (play),
    .loop        (loop),
    .Audio_Reset (Audio_Reset),
    .Start_Addr  (Start_Addr),
    .End_Addr    (End_Addr),
    .sample_tick (sample_tick),
    .mem         (mif),
    .sample_out  (sample_out),
    .busy        (busy),
    .underrun    (underrun)
  );

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  bit          mon_en = 1'b0;
  int          ucnt = 0;
  int          req_cycles = 0;
  int          lat = 3;
  int          tick_period = 20;
  int          tick_cnt = 0;
  bit          tick_sync = 1'b0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [22:0] paddr = '0;
  logic [15:0] last_out = '0;

  function automatic logic [15:0] mem_val(input logic [22:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd37 + 32'h1234;
    return t[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, memory model and tick generator, all on the falling edge.
  always @(negedge Clk) begin
    if (underrun === 1'b1) ucnt++;
    if (mon_en) begin
      if (sample_tick) begin
        if (underrun === 1'b1) begin
          check("hold_on_underrun", 32'(sample_out), 32'(last_out));
        end else if (sample_out !== last_out) begin
          if (exp_q.size() == 0) check("unexpected_sample", 32'(sample_out), 32'(last_out));
          else check("sample", 32'(sample_out), 32'(exp_q.pop_front()));
        end
      end else begin
        check("no_update_without_tick", 32'(sample_out), 32'(last_out));
      end
    end
    last_out = sample_out;

    if (mif.mem_rd_req === 1'b1) req_cycles++;
    mif.mem_rd_ack   = 1'b0;
    mif.mem_rd_valid = 1'b0;
    if (pend) begin
      check("no_req_while_pending", 32'(mif.mem_rd_req), 32'd0);
      cnt--;
      if (cnt <= 0) begin
        mif.mem_rd_valid = 1'b1;
        mif.mem_rd_data  = mem_val(paddr);
        pend = 1'b0;
      end
    end else if (mif.mem_rd_req === 1'b1) begin
      mif.mem_rd_ack = 1'b1;
      pend  = 1'b1;
      cnt   = lat;
      paddr = mif.mem_addr;
    end

    if (tick_sync) begin
      tick_cnt  = 0;
      tick_sync = 1'b0;
    end
    tick_cnt++;
    if (tick_cnt >= tick_period) begin
      sample_tick = 1'b1;
      tick_cnt    = 0;
    end else begin
      sample_tick = 1'b0;
    end
  end

  task automatic push_range(input logic [22:0] s, input logic [22:0] e);
    for (logic [22:0] a = s; a <= e; a++) exp_q.push_back(mem_val(a));
  endtask

  task automatic start_effect(input logic [22:0] s, input logic [22:0] e, input logic lp,
                              input int latency);
    @(negedge Clk);
    lat         = latency;
    Start_Addr  = s;
    End_Addr    = e;
    loop        = lp;
    Audio_Reset = 1'b0;
    play        = 1'b1;
    tick_sync   = 1'b1;
    ucnt        = 0;
    mon_en      = 1'b1;
  endtask

  task automatic stop_effect();
    @(negedge Clk);
    mon_en = 1'b0;
    play   = 1'b0;
    repeat (40) @(negedge Clk);
    exp_q.delete();
  endtask

  task automatic wait_qsize(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while ((exp_q.size() > n) && (i < budget)) begin
      @(negedge Clk);
      i++;
    end
    check(tag, 32'(exp_q.size()), 32'(n));
  endtask

  task automatic wait_ack(input int budget, input string tag);
    int  i;
    logic got;
    i   = 0;
    got = 1'b0;
    while (!got && (i < budget)) begin
      @(posedge Clk);
      if (mif.mem_rd_ack === 1'b1) got = 1'b1;
      i++;
    end
    check(tag, 32'(got), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},      32'(mif.mem_rd_req), 32'd0);
    check({tag, "_addr"},     32'(mif.mem_addr),   32'd0);
    check({tag, "_sample"},   32'(sample_out),     32'(SILENCE));
    check({tag, "_busy"},     32'(busy),           32'd0);
    check({tag, "_underrun"}, 32'(underrun),       32'd0);
  endtask

  initial begin
    int rc;
    Reset       = 1'b1;
    play        = 1'b0;
    loop        = 1'b0;
    Audio_Reset = 1'b0;
    Start_Addr  = '0;
    End_Addr    = '0;
    repeat (3) @(negedge Clk);
    check_reset_outputs("reset");
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Basic: four samples then silence, busy drops on the 4th tick.
    push_range(23'd100, 23'd103);
    exp_q.push_back(SILENCE);
    start_effect(23'd100, 23'd103, 1'b0, 3);
    repeat (3) @(negedge Clk);
    check("basic_busy_during_play", 32'(busy), 32'd1);
    wait_qsize(1, 400, "basic_four_samples");
    check("basic_busy_after_4th", 32'(busy), 32'd0);
    wait_qsize(0, 100, "basic_silence");
    check("basic_no_underrun", 32'(ucnt), 32'd0);
    stop_effect();

    // Loop over a two-sample range.
    for (int k = 0; k < 3; k++) push_range(23'd174715, 23'd174716);
    start_effect(23'd174715, 23'd174716, 1'b1, 3);
    wait_qsize(0, 600, "loop_sequence");
    check("loop_no_underrun", 32'(ucnt), 32'd0);
    stop_effect();

    // Slow memory: underruns, but every sample still appears in order.
    push_range(23'd300, 23'd303);
    exp_q.push_back(SILENCE);
    start_effect(23'd300, 23'd303, 1'b0, 30);
    wait_qsize(0, 1500, "underrun_all_samples");
    check("underrun_seen", 32'(ucnt > 0), 32'd1);
    stop_effect();

    // Abort one cycle after ack; the stale reply must be dropped.
    start_effect(23'd500, 23'd510, 1'b0, 10);
    wait_ack(100, "abort_first_ack");
    @(negedge Clk);
    mon_en      = 1'b0;
    Audio_Reset = 1'b1;
    Start_Addr  = 23'd3891;
    End_Addr    = 23'd3893;
    @(negedge Clk);
    Audio_Reset = 1'b0;
    push_range(23'd3891, 23'd3893);
    exp_q.push_back(SILENCE);
    tick_sync = 1'b1;
    mon_en    = 1'b1;
    wait_qsize(0, 800, "abort_new_effect");
    stop_effect();

    // Single-sample range.
    exp_q.push_back(mem_val(23'd5));
    exp_q.push_back(SILENCE);
    start_effect(23'd5, 23'd5, 1'b0, 3);
    wait_qsize(0, 200, "single_sample");
    check("single_busy_done", 32'(busy), 32'd0);
    stop_effect();

    // Reversed range: no fetch at all.
    rc = req_cycles;
    start_effect(23'd10, 23'd9, 1'b0, 3);
    repeat (30) @(negedge Clk);
    check("reverse_no_req", 32'(req_cycles - rc), 32'd0);
    check("reverse_not_busy", 32'(busy), 32'd0);
    stop_effect();

    // Asynchronous reset while a read is outstanding.
    push_range(23'd200, 23'd203);
    start_effect(23'd200, 23'd203, 1'b0, 15);
    wait_qsize(2, 400, "midwait_two_samples");
    wait_ack(100, "midwait_ack");
    #3;
    Reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    mon_en = 1'b0;
    play   = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      check("no_spurious_after_reset", 32'(sample_out), 32'(SILENCE));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
